// File: rtl/bram_rmw_ctrl_if.sv
// Requester-side handshake bundle for bram_rmw_ctrl: request channel
// (valid/ready plus store/load fields) and held response channel.
interface bram_rmw_ctrl_if #(
  parameter int WADDR = 10,
  parameter int WDATA = 32
);
  localparam int NBE = WDATA / 8;

  logic             pi_req_valid;
  logic             po_req_ready;
  logic             pi_req_we;
  logic [WADDR-1:0] pi_req_addr;
  logic [NBE-1:0]   pi_req_be;
  logic [WDATA-1:0] pi_req_wdata;
  logic             po_rsp_valid;
  logic             pi_rsp_ready;
  logic [WDATA-1:0] po_rsp_rdata;

  // Requester (core load/store path or bench driver)
  modport master (
    output pi_req_valid, pi_req_we, pi_req_addr, pi_req_be, pi_req_wdata, pi_rsp_ready,
    input  po_req_ready, po_rsp_valid, po_rsp_rdata
  );

  // Controller
  modport slave (
    input  pi_req_valid, pi_req_we, pi_req_addr, pi_req_be, pi_req_wdata, pi_rsp_ready,
    output po_req_ready, po_rsp_valid, po_rsp_rdata
  );
endinterface

// File: rtl/bram_rmw_ctrl.sv
// Byte-enabled request/response front-end for one BRAM port. Full-word
// stores write directly, partial stores do read-then-merge-write, loads
// capture the BRAM's registered read data into a held response.
module bram_rmw_ctrl #(
  parameter int WADDR = 10,
  parameter int WDATA = 32
) (
  input  logic             pi_clk,
  input  logic             pi_rstn,
  bram_rmw_ctrl_if.slave   req_if,
  output logic             po_bram_en,
  output logic             po_bram_we,
  output logic [WADDR-1:0] po_bram_addr,
  output logic [WDATA-1:0] po_bram_di,
  input  logic [WDATA-1:0] pi_bram_do
);
  localparam int NBE = WDATA / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, MERGE = 2'd2, RSP = 2'd3} state_t;

  state_t           state_q, state_d;
  logic [WADDR-1:0] req_addr_q, req_addr_d;
  logic [NBE-1:0]   req_be_q, req_be_d;
  logic [WDATA-1:0] req_wdata_q, req_wdata_d;
  logic             req_we_q, req_we_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WDATA-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [WADDR-1:0] addr_hold_q;
  logic [WDATA-1:0] di_hold_q;
  logic             en_s, we_s, ready_s, accept_s;
  logic [WADDR-1:0] addr_s;
  logic [WDATA-1:0] di_s;

  // Per-lane select: enabled lanes take new data, others keep the old word.
  function automatic logic [WDATA-1:0] merge_lanes(input logic [WDATA-1:0] new_w,
                                                   input logic [WDATA-1:0] old_w,
                                                   input logic [NBE-1:0]   be);
    logic [WDATA-1:0] res;
    res = old_w;
    for (int i = 0; i < NBE; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  // Next-state, request latch, response update and BRAM port drive.
  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_be_d    = req_be_q;
    req_wdata_d = req_wdata_q;
    req_we_d    = req_we_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    en_s        = 1'b0;
    we_s        = 1'b0;
    addr_s      = addr_hold_q;
    di_s        = di_hold_q;
    ready_s     = 1'b0;
    accept_s    = 1'b0;
    case (state_q)
      IDLE: begin
        ready_s  = pi_rstn;
        accept_s = req_if.pi_req_valid & pi_rstn;
        if (accept_s) begin
          req_addr_d  = req_if.pi_req_addr;
          req_be_d    = req_if.pi_req_be;
          req_wdata_d = req_if.pi_req_wdata;
          req_we_d    = req_if.pi_req_we;
          if (!req_if.pi_req_we) begin
            en_s    = 1'b1;
            addr_s  = req_if.pi_req_addr;
            state_d = RD;
          end else if (req_if.pi_req_be == {NBE{1'b1}}) begin
            en_s        = 1'b1;
            we_s        = 1'b1;
            addr_s      = req_if.pi_req_addr;
            di_s        = req_if.pi_req_wdata;
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = {WDATA{1'b0}};
          end else if (req_if.pi_req_be == {NBE{1'b0}}) begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = {WDATA{1'b0}};
          end else begin
            // Partial store: fetch the old word first.
            en_s    = 1'b1;
            addr_s  = req_if.pi_req_addr;
            state_d = MERGE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        rsp_rdata_d = pi_bram_do;
        rsp_valid_d = 1'b1;
        state_d     = RSP;
      end
      MERGE: begin
        en_s        = 1'b1;
        we_s        = 1'b1;
        addr_s      = req_addr_q;
        di_s        = merge_lanes(req_wdata_q, pi_bram_do, req_be_q);
        rsp_valid_d = 1'b1;
        rsp_rdata_d = {WDATA{1'b0}};
        state_d     = RSP;
      end
      RSP: begin
        if (req_if.pi_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = RSP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched request, response and address/data hold registers.
  always_ff @(posedge pi_clk) begin
    if (!pi_rstn) begin
      state_q     <= IDLE;
      req_addr_q  <= {WADDR{1'b0}};
      req_be_q    <= {NBE{1'b0}};
      req_wdata_q <= {WDATA{1'b0}};
      req_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {WDATA{1'b0}};
      addr_hold_q <= {WADDR{1'b0}};
      di_hold_q   <= {WDATA{1'b0}};
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_be_q    <= req_be_d;
      req_wdata_q <= req_wdata_d;
      req_we_q    <= req_we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      addr_hold_q <= addr_s;
      di_hold_q   <= di_s;
    end
  end

  // Reset forces the BRAM port idle, which also aborts a MERGE write.
  assign po_bram_en          = en_s & pi_rstn;
  assign po_bram_we          = we_s & pi_rstn;
  assign po_bram_addr        = addr_s;
  assign po_bram_di          = di_s;
  assign req_if.po_req_ready = ready_s;
  assign req_if.po_rsp_valid = rsp_valid_q;
  assign req_if.po_rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_bram_rmw_ctrl.sv
// Directed bench for bram_rmw_ctrl with a behavioural one-cycle-latency BRAM.
module tb_bram_rmw_ctrl;
  localparam int WADDR = 10;
  localparam int WDATA = 32;

  logic             clk = 1'b0;
  logic             rstn;
  logic             bram_en, bram_we;
  logic [WADDR-1:0] bram_addr;
  logic [WDATA-1:0] bram_di;
  logic [WDATA-1:0] bram_do;
  logic [WDATA-1:0] mem [0:(1<<WADDR)-1];
  int               n_writes = 0;
  int               errors = 0;
  int               checks = 0;
  logic [WDATA-1:0] held;

  bram_rmw_ctrl_if #(.WADDR(WADDR), .WDATA(WDATA)) bus ();

  bram_rmw_ctrl #(.WADDR(WADDR), .WDATA(WDATA)) dut (
    .pi_clk       (clk),
    .pi_rstn      (rstn),
    .req_if       (bus.slave),
    .po_bram_en   (bram_en),
    .po_bram_we   (bram_we),
    .po_bram_addr (bram_addr),
    .po_bram_di   (bram_di),
    .pi_bram_do   (bram_do)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < (1<<WADDR); i++) mem[i] = 32'h0;
    bram_do = 32'h0;
  end

  // Behavioural BRAM: write-enable cycles leave the read register alone.
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) begin
        mem[bram_addr] <= bram_di;
        n_writes       <= n_writes + 1;
      end else begin
        bram_do <= mem[bram_addr];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic load_check(input logic [9:0] a, input logic [31:0] exp, input string tag);
    cyc();
    bus.pi_rsp_ready = 1'b0; bus.pi_req_valid = 1'b1; bus.pi_req_we = 1'b0;
    bus.pi_req_addr = a; bus.pi_req_be = 4'h0;
    #1;
    check_eq({tag, "_acc_ready"}, 64'(bus.po_req_ready), 64'd1);
    check_eq({tag, "_acc_en"}, 64'(bram_en), 64'd1);
    check_eq({tag, "_acc_we"}, 64'(bram_we), 64'd0);
    check_eq({tag, "_acc_addr"}, 64'(bram_addr), 64'(a));
    cyc();
    bus.pi_req_valid = 1'b0;
    #1;
    check_eq({tag, "_rd_valid"}, 64'(bus.po_rsp_valid), 64'd0);
    check_eq({tag, "_rd_en"}, 64'(bram_en), 64'd0);
    cyc();
    bus.pi_rsp_ready = 1'b1;
    #1;
    check_eq({tag, "_rsp_valid"}, 64'(bus.po_rsp_valid), 64'd1);
    check_eq({tag, "_rsp_rdata"}, 64'(bus.po_rsp_rdata), 64'(exp));
  endtask

  task automatic store_full(input logic [9:0] a, input logic [31:0] d, input string tag);
    cyc();
    bus.pi_rsp_ready = 1'b0; bus.pi_req_valid = 1'b1; bus.pi_req_we = 1'b1;
    bus.pi_req_addr = a; bus.pi_req_be = 4'hF; bus.pi_req_wdata = d;
    #1;
    check_eq({tag, "_en"}, 64'(bram_en), 64'd1);
    check_eq({tag, "_we"}, 64'(bram_we), 64'd1);
    check_eq({tag, "_addr"}, 64'(bram_addr), 64'(a));
    check_eq({tag, "_di"}, 64'(bram_di), 64'(d));
    cyc();
    bus.pi_req_valid = 1'b0; bus.pi_rsp_ready = 1'b1;
    #1;
    check_eq({tag, "_rsp_valid"}, 64'(bus.po_rsp_valid), 64'd1);
    check_eq({tag, "_rsp_rdata"}, 64'(bus.po_rsp_rdata), 64'd0);
    check_eq({tag, "_rsp_en"}, 64'(bram_en), 64'd0);
  endtask

  initial begin
    rstn = 1'b0;
    bus.pi_req_valid = 1'b1; bus.pi_req_we = 1'b1; bus.pi_req_addr = 10'h005;
    bus.pi_req_be = 4'hF; bus.pi_req_wdata = 32'hDEADBEEF; bus.pi_rsp_ready = 1'b0;

    // Reset held with a pending request
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      check_eq("rst_ready", 64'(bus.po_req_ready), 64'd0);
      check_eq("rst_en", 64'(bram_en), 64'd0);
      check_eq("rst_rsp_valid", 64'(bus.po_rsp_valid), 64'd0);
      check_eq("rst_rdata", 64'(bus.po_rsp_rdata), 64'd0);
    end

    // First cycle out of reset accepts the full store
    cyc();
    rstn = 1'b1;
    #1;
    check_eq("first_ready", 64'(bus.po_req_ready), 64'd1);
    check_eq("st1_en", 64'(bram_en), 64'd1);
    check_eq("st1_we", 64'(bram_we), 64'd1);
    check_eq("st1_di", 64'(bram_di), 64'hDEADBEEF);
    cyc();
    bus.pi_req_valid = 1'b0; bus.pi_rsp_ready = 1'b1;
    #1;
    check_eq("st1_rsp_valid", 64'(bus.po_rsp_valid), 64'd1);
    check_eq("st1_rsp_rdata", 64'(bus.po_rsp_rdata), 64'd0);
    check_eq("st1_rsp_ready", 64'(bus.po_req_ready), 64'd0);

    load_check(10'h005, 32'hDEADBEEF, "ld1");

    // Partial store, byte lane 1
    cyc();
    bus.pi_rsp_ready = 1'b0; bus.pi_req_valid = 1'b1; bus.pi_req_we = 1'b1;
    bus.pi_req_addr = 10'h005; bus.pi_req_be = 4'h2; bus.pi_req_wdata = 32'h0000AA00;
    #1;
    check_eq("rmw_rd_en", 64'(bram_en), 64'd1);
    check_eq("rmw_rd_we", 64'(bram_we), 64'd0);
    cyc();
    bus.pi_req_valid = 1'b0;
    #1;
    check_eq("rmw_wr_en", 64'(bram_en), 64'd1);
    check_eq("rmw_wr_we", 64'(bram_we), 64'd1);
    check_eq("rmw_wr_addr", 64'(bram_addr), 64'h005);
    check_eq("rmw_wr_di", 64'(bram_di), 64'hDEADAAEF);
    check_eq("rmw_wr_valid", 64'(bus.po_rsp_valid), 64'd0);
    cyc();
    bus.pi_rsp_ready = 1'b1;
    #1;
    check_eq("rmw_rsp_valid", 64'(bus.po_rsp_valid), 64'd1);
    check_eq("rmw_rsp_rdata", 64'(bus.po_rsp_rdata), 64'd0);
    check_eq("rmw_rsp_en", 64'(bram_en), 64'd0);

    load_check(10'h005, 32'hDEADAAEF, "ld2");

    // Zero-byte-enable store: no BRAM activity
    cyc();
    bus.pi_rsp_ready = 1'b0; bus.pi_req_valid = 1'b1; bus.pi_req_we = 1'b1;
    bus.pi_req_addr = 10'h005; bus.pi_req_be = 4'h0; bus.pi_req_wdata = 32'h12345678;
    #1;
    check_eq("be0_ready", 64'(bus.po_req_ready), 64'd1);
    check_eq("be0_en", 64'(bram_en), 64'd0);
    cyc();
    bus.pi_req_valid = 1'b0; bus.pi_rsp_ready = 1'b1;
    #1;
    check_eq("be0_rsp_valid", 64'(bus.po_rsp_valid), 64'd1);
    check_eq("be0_rsp_rdata", 64'(bus.po_rsp_rdata), 64'd0);
    check_eq("be0_rsp_en", 64'(bram_en), 64'd0);

    load_check(10'h005, 32'hDEADAAEF, "ld3");

    // Load with a five-cycle response stall
    cyc();
    bus.pi_rsp_ready = 1'b0; bus.pi_req_valid = 1'b1; bus.pi_req_we = 1'b0;
    bus.pi_req_addr = 10'h005;
    #1;
    check_eq("stall_acc_en", 64'(bram_en), 64'd1);
    cyc();
    bus.pi_req_valid = 1'b1;
    #1;
    check_eq("stall_rd_ready", 64'(bus.po_req_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      check_eq("stall_valid", 64'(bus.po_rsp_valid), 64'd1);
      check_eq("stall_rdata", 64'(bus.po_rsp_rdata), 64'hDEADAAEF);
      check_eq("stall_ready", 64'(bus.po_req_ready), 64'd0);
      check_eq("stall_en", 64'(bram_en), 64'd0);
    end
    cyc();
    bus.pi_req_valid = 1'b0; bus.pi_rsp_ready = 1'b1;
    #1;
    check_eq("stall_hs_valid", 64'(bus.po_rsp_valid), 64'd1);
    check_eq("stall_hs_rdata", 64'(bus.po_rsp_rdata), 64'hDEADAAEF);
    cyc();
    bus.pi_rsp_ready = 1'b0;
    #1;
    check_eq("stall_idle_ready", 64'(bus.po_req_ready), 64'd1);
    check_eq("stall_idle_valid", 64'(bus.po_rsp_valid), 64'd0);

    // Reset during MERGE aborts the write
    store_full(10'h010, 32'h11223344, "st2");
    cyc();
    bus.pi_rsp_ready = 1'b0; bus.pi_req_valid = 1'b1; bus.pi_req_we = 1'b1;
    bus.pi_req_addr = 10'h010; bus.pi_req_be = 4'h1; bus.pi_req_wdata = 32'h000000FF;
    #1;
    check_eq("abort_rd_en", 64'(bram_en), 64'd1);
    check_eq("abort_rd_we", 64'(bram_we), 64'd0);
    cyc();
    rstn = 1'b0; bus.pi_req_valid = 1'b0;
    #1;
    check_eq("abort_merge_en", 64'(bram_en), 64'd0);
    check_eq("abort_merge_we", 64'(bram_we), 64'd0);
    cyc();
    rstn = 1'b1;
    #1;
    check_eq("abort_post_valid", 64'(bus.po_rsp_valid), 64'd0);
    check_eq("abort_post_ready", 64'(bus.po_req_ready), 64'd1);
    load_check(10'h010, 32'h11223344, "ld4");

    cyc();
    bus.pi_rsp_ready = 1'b0;
    #1;
    check_eq("write_count", 64'(n_writes), 64'd3);
    check_eq("mem_005", 64'(mem[10'h005]), 64'hDEADAAEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bram_rmw_ctrl.md
Name: bram_rmw_ctrl

Overview:
Request/response front-end that owns one port of the dual-port BRAM and converts byte-enabled word requests into BRAM port accesses. Full-word stores are single writes. Partial stores become a read-modify-write, because the BRAM port has only a word-wide write enable. Loads capture the BRAM's one-cycle registered read data into a held response. The block sits directly upstream of the BRAM port; the requester side is the core's load/store path or the testbench driver.

Parameters:
WADDR, 10, BRAM word-address width (matches the BRAM's WADDR)
WDATA, 32, data width; must be a multiple of 8; NBE = WDATA/8 byte lanes (derived localparam)

Ports:
pi_clk  in  1  single clock for all logic; drives the BRAM port clock
pi_rstn  in  1  reset, synchronous, active-low
pi_req_valid  in  1  request valid
po_req_ready  out  1  request accepted when valid&ready at a rising edge
pi_req_we  in  1  1 = store, 0 = load
pi_req_addr  in  WADDR  word address
pi_req_be  in  NBE  byte enables for a store, bit i = bits [8i+7:8i]; ignored for loads
pi_req_wdata  in  WDATA  store data
po_rsp_valid  out  1  response valid, held until accepted
pi_rsp_ready  in  1  response accepted when valid&ready
po_rsp_rdata  out  WDATA  load data; 0 for store responses
po_bram_en  out  1  to BRAM port enable
po_bram_we  out  1  to BRAM port write enable
po_bram_addr  out  WADDR  to BRAM port address
po_bram_di  out  WDATA  to BRAM port write data
pi_bram_do  in  WDATA  from BRAM port read data (valid the cycle after a read-enable cycle; unchanged by write cycles)

Behaviour:
- FSM states: IDLE, RD, MERGE, RSP. po_req_ready = (state==IDLE) & pi_rstn.
- Request fields (addr, be, wdata, we) are latched on accept.
- BRAM outputs are combinational from state and inputs. Accept-cycle outputs come from the request inputs; MERGE outputs come from the latched request. Outside an access: en=0, we=0, addr and di hold their last value.
- Accept of a load in cycle T:
  - T: en=1, we=0, addr=req_addr. Next state RD.
  - T+1 (RD): pi_bram_do is registered into po_rsp_rdata. Next state RSP.
  - po_rsp_valid rises at T+2.
- Accept of a store with be all ones in cycle T:
  - T: en=1, we=1, addr=req_addr, di=req_wdata. Next state RSP.
  - po_rsp_valid at T+1; rdata=0.
- Accept of a store with be partial (nonzero, not all ones) in cycle T:
  - T: en=1, we=0 (read old word). Next state MERGE.
  - T+1 (MERGE): en=1, we=1, addr=latched addr. di lane i = be[i] ? wdata lane i : pi_bram_do lane i. Next state RSP.
  - po_rsp_valid at T+2.
- Store with be=0: no BRAM activity (en stays 0). Next state RSP; po_rsp_valid at T+1.
- RSP state:
  - po_rsp_valid=1 and po_rsp_rdata stable until pi_rsp_ready=1 at an edge, then IDLE.
  - No new request is accepted in RSP; the next accept is possible the cycle after the response handshake.
- Exactly one BRAM write cycle per nonzero-be store; never a write for loads.
- The controller never relies on pi_bram_do after a write cycle.
- Reset (pi_rstn=0 at a rising edge):
  - state=IDLE, po_rsp_valid=0, po_rsp_rdata=0, latched request=0.
  - While pi_rstn=0: po_bram_en=0, po_bram_we=0, po_req_ready=0.
  - Reset during MERGE aborts the write, leaving the BRAM word unchanged.
  - Reset during RSP drops the pending response.

Test Plan:
- Hold pi_rstn=0 for 3 cycles with pi_req_valid=1 -> po_req_ready=0, po_bram_en=0, po_rsp_valid=0, po_rsp_rdata=0 throughout; first accept occurs the first cycle pi_rstn=1.
- Store addr 0x005, data 0xDEADBEEF, be 0xF accepted at T -> single en=1/we=1 cycle at T with di 0xDEADBEEF; rsp_valid at T+1. Then load 0x005 accepted at L -> rsp_valid at L+2 with rdata 0xDEADBEEF.
- With 0x005=0xDEADBEEF, store data 0x0000AA00, be 0x2 at T -> read at T, write at T+1 with di 0xDEADAAEF; rsp_valid at T+2; subsequent load returns 0xDEADAAEF.
- Store be 0x0 to 0x005 -> no en pulse, rsp_valid at T+1 with rdata 0; memory still 0xDEADAAEF.
- Load with pi_rsp_ready=0 for 5 cycles -> rsp_valid and rdata held constant, po_req_ready=0, en=0 during the stall; handshake on cycle 6 returns to IDLE.
- 0x010=0x11223344; partial store be 0x1, data 0xFF, with pi_rstn=0 in the MERGE cycle -> no we pulse; after reset, load 0x010 returns 0x11223344.
